// File: rtl/csr_commit.sv
// Writeback commit stage: retires MEM instructions, performs CSR accesses, raises
// exception/ertn flushes and holds the fetch redirect until fetch acknowledges it.
module csr_commit #(
   parameter int unsigned CSR_NUM_W     = 14,
   parameter logic [31:0] ALL_ONES_MASK = 32'hFFFF_FFFF
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 ms_valid_i,
   output logic                 ms_ready_o,
   input  logic [31:0]          ms_pc_i,
   input  logic [1:0]           ms_csr_op_i,
   input  logic [CSR_NUM_W-1:0] ms_csr_num_i,
   input  logic [31:0]          ms_rkd_value_i,
   input  logic [31:0]          ms_rj_value_i,
   input  logic                 ms_gr_we_i,
   input  logic [4:0]           ms_dest_i,
   input  logic [31:0]          ms_result_i,
   input  logic                 ms_ertn_i,
   input  logic [4:0]           ms_excp_i,
   input  logic [31:0]          ms_vaddr_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [31:0]          rf_wdata_o,
   output logic                 csr_we_o,
   output logic [CSR_NUM_W-1:0] csr_num_o,
   output logic [31:0]          csr_wmask_o,
   output logic [31:0]          csr_wdata_o,
   input  logic [31:0]          csr_rdata_i,
   output logic                 excp_flush_o,
   output logic                 ertn_flush_o,
   output logic [5:0]           ecode_o,
   output logic [2:0]           esubcode_o,
   output logic [31:0]          epc_o,
   output logic [31:0]          eaddr_o,
   input  logic [31:0]          era_i,
   input  logic [31:0]          eentry_i,
   input  logic                 has_int_i,
   output logic                 flush_pipe_o,
   output logic                 redir_valid_o,
   output logic [31:0]          redir_pc_o,
   input  logic                 redir_ack_i
);

   typedef enum logic {StRun, StRedir} state_e;

   localparam logic [1:0] OpNone = 2'b00;
   localparam logic [1:0] OpWr   = 2'b10;
   localparam logic [1:0] OpXchg = 2'b11;

   state_e                 state_q, state_d;
   logic                   ws_valid_q, ws_valid_d;
   logic                   redir_valid_q, redir_valid_d;
   logic [31:0]            redir_pc_q, redir_pc_d;

   logic [31:0]            ws_pc_q, ws_rkd_q, ws_rj_q, ws_result_q, ws_vaddr_q;
   logic [1:0]             ws_csr_op_q;
   logic [CSR_NUM_W-1:0]   ws_csr_num_q;
   logic                   ws_gr_we_q, ws_ertn_q;
   logic [4:0]             ws_dest_q, ws_excp_q;

   logic                   commit, excp_commit, ertn_commit, load_payload;

   assign ms_ready_o   = 1'b1;
   assign load_payload = ms_valid_i && ms_ready_o;

   assign commit      = ws_valid_q && (state_q == StRun);
   assign excp_commit = commit && (has_int_i || (|ws_excp_q));
   assign ertn_commit = commit && !excp_commit && ws_ertn_q;

   assign excp_flush_o  = excp_commit;
   assign ertn_flush_o  = ertn_commit;
   assign flush_pipe_o  = (state_q == StRedir) || excp_commit || ertn_commit;
   assign epc_o         = ws_pc_q;
   assign eaddr_o       = ws_vaddr_q;
   assign esubcode_o    = 3'd0;
   assign redir_valid_o = redir_valid_q;
   assign redir_pc_o    = redir_pc_q;

   // Exception code, highest priority first: int, adef, ine, sys, brk, ale.
   always_comb begin
      ecode_o = 6'h00;
      if (excp_commit) begin
         if (has_int_i)         ecode_o = 6'h00;
         else if (ws_excp_q[4]) ecode_o = 6'h08;
         else if (ws_excp_q[3]) ecode_o = 6'h0D;
         else if (ws_excp_q[2]) ecode_o = 6'h0B;
         else if (ws_excp_q[1]) ecode_o = 6'h0C;
         else                   ecode_o = 6'h09;
      end
   end

   always_comb begin
      csr_num_o   = ws_valid_q ? ws_csr_num_q : '0;
      csr_we_o    = 1'b0;
      csr_wmask_o = 32'h0;
      csr_wdata_o = ws_rkd_q;
      if (ws_csr_op_q == OpWr)   csr_wmask_o = ALL_ONES_MASK;
      if (ws_csr_op_q == OpXchg) csr_wmask_o = ws_rj_q;
      if (commit && !excp_commit && !ertn_commit &&
          (ws_csr_op_q == OpWr || ws_csr_op_q == OpXchg)) begin
         csr_we_o = 1'b1;
      end
      rf_we_o    = commit && !excp_commit && ws_gr_we_q;
      rf_waddr_o = ws_dest_q;
      // CSR reads return the value before this cycle's write lands.
      rf_wdata_o = (ws_csr_op_q != OpNone) ? csr_rdata_i : ws_result_q;
   end

   always_comb begin
      state_d       = state_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      ws_valid_d    = load_payload && !flush_pipe_o;
      unique case (state_q)
         StRun: begin
            if (excp_commit || ertn_commit) begin
               state_d       = StRedir;
               redir_valid_d = 1'b1;
               redir_pc_d    = excp_commit ? eentry_i : era_i;
            end
         end
         StRedir: begin
            if (redir_ack_i && redir_valid_q) begin
               state_d       = StRun;
               redir_valid_d = 1'b0;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StRun;
         ws_valid_q    <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= 32'h0;
      end else begin
         state_q       <= state_d;
         ws_valid_q    <= ws_valid_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ws_pc_q      <= 32'h0;
         ws_csr_op_q  <= OpNone;
         ws_csr_num_q <= '0;
         ws_rkd_q     <= 32'h0;
         ws_rj_q      <= 32'h0;
         ws_gr_we_q   <= 1'b0;
         ws_dest_q    <= 5'd0;
         ws_result_q  <= 32'h0;
         ws_ertn_q    <= 1'b0;
         ws_excp_q    <= 5'd0;
         ws_vaddr_q   <= 32'h0;
      end else if (load_payload) begin
         ws_pc_q      <= ms_pc_i;
         ws_csr_op_q  <= ms_csr_op_i;
         ws_csr_num_q <= ms_csr_num_i;
         ws_rkd_q     <= ms_rkd_value_i;
         ws_rj_q      <= ms_rj_value_i;
         ws_gr_we_q   <= ms_gr_we_i;
         ws_dest_q    <= ms_dest_i;
         ws_result_q  <= ms_result_i;
         ws_ertn_q    <= ms_ertn_i;
         ws_excp_q    <= ms_excp_i;
         ws_vaddr_q   <= ms_vaddr_i;
      end
   end

endmodule

// File: tb/tb_csr_commit.sv
// Directed bench for csr_commit: CSR ops, exception/ertn flushes, redirect handshake,
// interrupt priority and asynchronous reset during a redirect.
module tb_csr_commit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_valid, ms_ready;
   logic [31:0] ms_pc, ms_rkd_value, ms_rj_value, ms_result, ms_vaddr;
   logic [1:0]  ms_csr_op;
   logic [13:0] ms_csr_num;
   logic        ms_gr_we, ms_ertn;
   logic [4:0]  ms_dest, ms_excp;
   logic        rf_we, csr_we, excp_flush, ertn_flush, flush_pipe, redir_valid;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, csr_wmask, csr_wdata, csr_rdata, epc, eaddr, era, eentry, redir_pc;
   logic [13:0] csr_num;
   logic [5:0]  ecode;
   logic [2:0]  esubcode;
   logic        has_int, redir_ack;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   csr_commit dut (
      .clk_i(clk), .reset_i(reset),
      .ms_valid_i(ms_valid), .ms_ready_o(ms_ready), .ms_pc_i(ms_pc),
      .ms_csr_op_i(ms_csr_op), .ms_csr_num_i(ms_csr_num),
      .ms_rkd_value_i(ms_rkd_value), .ms_rj_value_i(ms_rj_value),
      .ms_gr_we_i(ms_gr_we), .ms_dest_i(ms_dest), .ms_result_i(ms_result),
      .ms_ertn_i(ms_ertn), .ms_excp_i(ms_excp), .ms_vaddr_i(ms_vaddr),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .csr_we_o(csr_we), .csr_num_o(csr_num), .csr_wmask_o(csr_wmask),
      .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
      .excp_flush_o(excp_flush), .ertn_flush_o(ertn_flush),
      .ecode_o(ecode), .esubcode_o(esubcode), .epc_o(epc), .eaddr_o(eaddr),
      .era_i(era), .eentry_i(eentry), .has_int_i(has_int),
      .flush_pipe_o(flush_pipe), .redir_valid_o(redir_valid),
      .redir_pc_o(redir_pc), .redir_ack_i(redir_ack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ms();
      ms_valid = 0; ms_pc = 0; ms_csr_op = 0; ms_csr_num = 0; ms_rkd_value = 0;
      ms_rj_value = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0; ms_ertn = 0;
      ms_excp = 0; ms_vaddr = 0;
   endtask

   task automatic ack_redir();
      redir_ack = 1;
      step();
      redir_ack = 0;
   endtask

   task automatic test_reset();
      reset = 1; clear_ms(); csr_rdata = 0; era = 0; eentry = 0; has_int = 0; redir_ack = 0;
      #12;
      vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_redir_valid got %b want 0", redir_valid); end
      vectors++; if (redir_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redir_pc got %h want 0", redir_pc); end
      vectors++; if ({excp_flush, ertn_flush, rf_we, csr_we, flush_pipe} !== 5'b0) begin miscompares++; $display("FAIL reset_outputs got %b want 00000", {excp_flush, ertn_flush, rf_we, csr_we, flush_pipe}); end
      vectors++; if (ms_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ms_ready got %b want 1", ms_ready); end
      @(negedge clk); reset = 0;
      step();
   endtask

   task automatic test_csrwr();
      ms_valid = 1; ms_csr_op = 2'b10; ms_csr_num = 14'h30; ms_rkd_value = 32'h1234_5678;
      ms_gr_we = 1; ms_dest = 5'd5;
      step();
      clear_ms(); csr_rdata = 32'hAAAA_0000; #1;
      vectors++; if (csr_we !== 1'b1) begin miscompares++; $display("FAIL csrwr_we got %b want 1", csr_we); end
      vectors++; if (csr_num !== 14'h30) begin miscompares++; $display("FAIL csrwr_num got %h want 30", csr_num); end
      vectors++; if (csr_wmask !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL csrwr_wmask got %h want ffffffff", csr_wmask); end
      vectors++; if (csr_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL csrwr_wdata got %h want 12345678", csr_wdata); end
      vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hAAAA_0000}) begin miscompares++; $display("FAIL csrwr_rf got %b/%0d/%h want 1/5/aaaa0000", rf_we, rf_waddr, rf_wdata); end
      step();
      vectors++; if ({rf_we, csr_we, csr_num} !== {2'b00, 14'h0}) begin miscompares++; $display("FAIL csrwr_idle got %b/%b/%h want 0/0/0", rf_we, csr_we, csr_num); end
   endtask

   task automatic test_csrxchg();
      ms_valid = 1; ms_csr_op = 2'b11; ms_csr_num = 14'h0; ms_rj_value = 32'h4;
      ms_rkd_value = 32'h4; ms_gr_we = 1; ms_dest = 5'd7;
      step();
      clear_ms(); csr_rdata = 32'h0000_0008; #1;
      vectors++; if ({csr_we, csr_wmask, csr_wdata} !== {1'b1, 32'h4, 32'h4}) begin miscompares++; $display("FAIL xchg_csr got %b/%h/%h want 1/4/4", csr_we, csr_wmask, csr_wdata); end
      vectors++; if (rf_wdata !== 32'h8) begin miscompares++; $display("FAIL xchg_rf_wdata got %h want 8", rf_wdata); end
      vectors++; if ({excp_flush, ertn_flush, flush_pipe} !== 3'b000) begin miscompares++; $display("FAIL xchg_noflush got %b want 000", {excp_flush, ertn_flush, flush_pipe}); end
      step();
   endtask

   task automatic test_back_to_back();
      // csrwr then csrrd of SAVE0 on consecutive cycles, then a plain ALU result
      ms_valid = 1; ms_csr_op = 2'b10; ms_csr_num = 14'h30; ms_rkd_value = 32'hCAFE_0001;
      ms_gr_we = 0;
      step();
      csr_rdata = 32'h1234_5678;
      ms_csr_op = 2'b01; ms_gr_we = 1; ms_dest = 5'd9; #1;
      vectors++; if ({csr_we, rf_we} !== 2'b10) begin miscompares++; $display("FAIL b2b_wr got we=%b rf_we=%b want 1/0", csr_we, rf_we); end
      step();
      csr_rdata = 32'hCAFE_0001;
      ms_csr_op = 2'b00; ms_result = 32'h0000_BEEF; ms_dest = 5'd10; #1;
      vectors++; if ({csr_we, rf_we, rf_waddr, rf_wdata} !== {2'b01, 5'd9, 32'hCAFE_0001}) begin miscompares++; $display("FAIL b2b_rd got %b/%b/%0d/%h want 0/1/9/cafe0001", csr_we, rf_we, rf_waddr, rf_wdata); end
      step();
      clear_ms(); #1;
      vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h0000_BEEF}) begin miscompares++; $display("FAIL b2b_alu got %b/%0d/%h want 1/10/0000beef", rf_we, rf_waddr, rf_wdata); end
      step();
   endtask

   task automatic test_syscall();
      eentry = 32'h1C00_8000; era = 32'h1C00_0FF0;
      ms_valid = 1; ms_pc = 32'h1C00_0100; ms_excp = 5'b00100; ms_gr_we = 1; ms_csr_op = 2'b10;
      step();
      // a younger instruction sits in MEM during the flush cycle and after
      clear_ms(); ms_valid = 1; ms_gr_we = 1; ms_dest = 5'd3; ms_result = 32'h5555; #1;
      vectors++; if ({excp_flush, ertn_flush, ecode, esubcode} !== {2'b10, 6'h0B, 3'd0}) begin miscompares++; $display("FAIL sys_flush got %b%b/%h/%0d want 10/0b/0", excp_flush, ertn_flush, ecode, esubcode); end
      vectors++; if (epc !== 32'h1C00_0100) begin miscompares++; $display("FAIL sys_epc got %h want 1c000100", epc); end
      vectors++; if ({rf_we, csr_we, flush_pipe, redir_valid} !== 4'b0010) begin miscompares++; $display("FAIL sys_side got %b want 0010", {rf_we, csr_we, flush_pipe, redir_valid}); end
      step();
      eentry = 32'h1C00_9999; #1;
      vectors++; if ({excp_flush, redir_valid, redir_pc} !== {2'b01, 32'h1C00_8000}) begin miscompares++; $display("FAIL sys_redir got %b/%b/%h want 0/1/1c008000", excp_flush, redir_valid, redir_pc); end
      vectors++; if ({flush_pipe, rf_we} !== 2'b10) begin miscompares++; $display("FAIL sys_drop got %b want 10", {flush_pipe, rf_we}); end
      step(); step();
      vectors++; if ({redir_valid, redir_pc, rf_we} !== {1'b1, 32'h1C00_8000, 1'b0}) begin miscompares++; $display("FAIL sys_hold got %b/%h/%b want 1/1c008000/0", redir_valid, redir_pc, rf_we); end
      ack_redir();
      vectors++; if ({redir_valid, flush_pipe, rf_we} !== 3'b000) begin miscompares++; $display("FAIL sys_ack got %b want 000", {redir_valid, flush_pipe, rf_we}); end
      clear_ms(); redir_ack = 1;
      step();
      redir_ack = 0;
      vectors++; if ({redir_valid, flush_pipe} !== 2'b00) begin miscompares++; $display("FAIL sys_stray_ack got %b want 00", {redir_valid, flush_pipe}); end
   endtask

   task automatic test_ertn();
      era = 32'h1C00_0104; eentry = 32'h1C00_8000;
      ms_valid = 1; ms_ertn = 1;
      step();
      clear_ms(); #1;
      vectors++; if ({ertn_flush, excp_flush, rf_we, csr_we, flush_pipe} !== 5'b10001) begin miscompares++; $display("FAIL ertn_flush got %b want 10001", {ertn_flush, excp_flush, rf_we, csr_we, flush_pipe}); end
      step();
      vectors++; if ({redir_valid, redir_pc} !== {1'b1, 32'h1C00_0104}) begin miscompares++; $display("FAIL ertn_redir got %b/%h want 1/1c000104", redir_valid, redir_pc); end
      ack_redir();
   endtask

   task automatic test_interrupt();
      has_int = 1; eentry = 32'h1C00_A000; era = 32'h1C00_0200; #1;
      vectors++; if ({excp_flush, flush_pipe} !== 2'b00) begin miscompares++; $display("FAIL int_idle got %b want 00", {excp_flush, flush_pipe}); end
      ms_valid = 1; ms_excp = 5'b01000; ms_ertn = 1;
      step();
      clear_ms(); #1;
      vectors++; if ({excp_flush, ertn_flush, ecode} !== {2'b10, 6'h00}) begin miscompares++; $display("FAIL int_prio got %b%b/%h want 10/00", excp_flush, ertn_flush, ecode); end
      has_int = 0;
      step();
      vectors++; if ({redir_valid, redir_pc} !== {1'b1, 32'h1C00_A000}) begin miscompares++; $display("FAIL int_redir got %b/%h want 1/1c00a000", redir_valid, redir_pc); end
      ack_redir();
   endtask

   task automatic test_ecode_table();
      logic [4:0] pats [5] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};
      logic [5:0] codes[5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      for (int i = 0; i < 5; i++) begin
         ms_valid = 1; ms_excp = pats[i];
         step();
         clear_ms(); #1;
         vectors++; if ({excp_flush, ecode} !== {1'b1, codes[i]}) begin miscompares++; $display("FAIL ecode_%b got %b/%h want 1/%h", pats[i], excp_flush, ecode, codes[i]); end
         step();
         ack_redir();
      end
   endtask

   task automatic test_ale_reset();
      eentry = 32'h1C00_8000;
      ms_valid = 1; ms_excp = 5'b00001; ms_vaddr = 32'h8000_0003; ms_pc = 32'h1C00_0300;
      step();
      clear_ms(); #1;
      vectors++; if ({excp_flush, ecode, eaddr} !== {1'b1, 6'h09, 32'h8000_0003}) begin miscompares++; $display("FAIL ale got %b/%h/%h want 1/09/80000003", excp_flush, ecode, eaddr); end
      step();
      vectors++; if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL ale_redir got %b want 1", redir_valid); end
      ms_valid = 1; ms_gr_we = 1;
      #2 reset = 1; #1;
      vectors++; if ({redir_valid, flush_pipe} !== 2'b00) begin miscompares++; $display("FAIL rst_redir got %b want 00", {redir_valid, flush_pipe}); end
      @(posedge clk); #1;
      vectors++; if ({rf_we, excp_flush, csr_num} !== {2'b00, 14'h0}) begin miscompares++; $display("FAIL rst_ws_valid got %b/%b/%h want 0/0/0", rf_we, excp_flush, csr_num); end
      clear_ms();
      @(negedge clk); reset = 0;
      step();
   endtask

   initial begin
      test_reset();
      test_csrwr();
      test_csrxchg();
      test_back_to_back();
      test_syscall();
      test_ertn();
      test_interrupt();
      test_ecode_table();
      test_ale_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
